comparison_unit: RTL and testbench



---
 rtl/comparison_unit.sv | 88 ++++++++
 tb/tb_comparison_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/comparison_unit.sv
// -----------------------------------------------------------------------------
// comparison_unit
//   Registered magnitude comparator for the ALU's second execution unit.
//   Operands are compared both as two's-complement signed and as unsigned
//   values. The packed flag word is registered, so it appears one clock after
//   the operands are sampled.
//
// Ports
//   i_clk     in   1     clock; all state updates on the rising edge
//   i_rst_n   in   1     synchronous active-low reset
//   i_argA    in   BITS  operand A
//   i_argB    in   BITS  operand B
//   o_result  out  BITS  flag word:
//                          bit0 EQ   A == B
//                          bit1 SGT  signed A > signed B
//                          bit2 SLT  signed A < signed B
//                          bit3 UGT  unsigned A > unsigned B
//                          bits BITS-1..4 always 0
// -----------------------------------------------------------------------------
module comparison_unit #(
    parameter int BITS = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic [BITS-1:0] o_result
);

    // MSB-first compare chain. Element i summarises bits BITS-1..i:
    //   eq_chain[i] : all of those bits match
    //   gt_chain[i] : A is already decided greater within those bits
    // Element BITS is the empty prefix (equal, not greater).
    logic [BITS:0] eq_chain;
    logic [BITS:0] gt_chain;

    assign eq_chain[BITS] = 1'b1;
    assign gt_chain[BITS] = 1'b0;

    for (genvar i = BITS - 1; i >= 0; i--) begin : g_chain
        logic bit_eq;
        logic bit_gt;

        assign bit_eq      = ~(i_argA[i] ^ i_argB[i]);
        assign bit_gt      = i_argA[i] & ~i_argB[i];
        // A greater bit only counts if every more-significant bit matched.
        assign eq_chain[i] = eq_chain[i+1] & bit_eq;
        assign gt_chain[i] = gt_chain[i+1] | (eq_chain[i+1] & bit_gt);
    end

    logic flag_eq;
    logic flag_ugt;
    logic flag_sgt;
    logic flag_slt;
    logic sign_a;
    logic sign_b;

    assign sign_a   = i_argA[BITS-1];
    assign sign_b   = i_argB[BITS-1];
    assign flag_eq  = eq_chain[0];
    assign flag_ugt = gt_chain[0];

    // With matching signs the signed and unsigned orders agree. With differing
    // signs the non-negative operand (MSB clear) is the greater one.
    assign flag_sgt = (sign_a == sign_b) ? flag_ugt : ~sign_a;
    assign flag_slt = ~flag_eq & ~flag_sgt;

    logic [BITS-1:0] flags_next;

    // Upper bits are left at the zero default so any BITS >= 4 works without
    // a zero-width replication.
    always_comb begin
        flags_next    = '0;
        flags_next[0] = flag_eq;
        flags_next[1] = flag_sgt;
        flags_next[2] = flag_slt;
        flags_next[3] = flag_ugt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_result <= '0;
        end else begin
            o_result <= flags_next;
        end
    end

endmodule

// File: tb/tb_comparison_unit.sv
module tb_comparison_unit;

    localparam int BITS = 4;

    logic            i_clk;
    logic            i_rst_n;
    logic [BITS-1:0] i_argA;
    logic [BITS-1:0] i_argB;
    logic [BITS-1:0] o_result;

    int tests_run;
    int tests_failed;

    logic [BITS-1:0] exp_q;
    logic            exp_valid;

    comparison_unit #(.BITS(BITS)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [BITS-1:0] model(input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
        int ua;
        int ub;
        int sa;
        int sb;
        logic [BITS-1:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = a[BITS-1] ? ua - (1 << BITS) : ua;
        sb = b[BITS-1] ? ub - (1 << BITS) : ub;
        r    = '0;
        r[0] = (ua == ub);
        r[1] = (sa > sb);
        r[2] = (sa < sb);
        r[3] = (ua > ub);
        return r;
    endfunction

    task automatic check(input string name, input logic [BITS-1:0] actual,
                         input logic [BITS-1:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b (A=%b B=%b rst_n=%b t=%0t)",
                     name, actual, required, i_argA, i_argB, i_rst_n, $time);
        end
    endtask

    // Model register: mirrors what the output must be after each edge.
    always @(posedge i_clk) begin
        exp_valid <= 1'b1;
        if (!i_rst_n) exp_q <= '0;
        else          exp_q <= model(i_argA, i_argB);
    end

    // Continuous compare on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (exp_valid === 1'b1) check("cycle", o_result, exp_q);
    end

    // Inputs are changed 2 time units after a rising edge; the caller then
    // checks 1 unit after the next rising edge.
    task automatic step(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input logic rst_n);
        i_argA  = a;
        i_argB  = b;
        i_rst_n = rst_n;
        @(posedge i_clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [BITS-1:0] a,
                            input logic [BITS-1:0] b, input logic [BITS-1:0] lit);
        step(a, b, 1'b1);
        check(name, o_result, lit);
        check({name, "_model"}, model(a, b), lit);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_valid    = 1'b0;
        exp_q        = '0;
        i_rst_n      = 1'b0;
        i_argA       = 4'b0101;
        i_argB       = 4'b0011;

        // Reset with non-trivial operands present: output must be 0.
        @(posedge i_clk); #1;
        check("reset", o_result, 4'b0000);
        #1;
        step(4'b0101, 4'b0011, 1'b0);
        check("reset_hold", o_result, 4'b0000);
        #1;

        // Release: output still 0 until the first evaluating edge.
        i_rst_n = 1'b1;
        #1;
        check("post_release", o_result, 4'b0000);
        #1;
        @(posedge i_clk); #2;

        directed("eq",         4'b0001, 4'b0001, 4'b0001);
        directed("minneg",     4'b1000, 4'b0001, 4'b1100);
        directed("sgt_ugt",    4'b0101, 4'b0011, 4'b1010);
        directed("minus1",     4'b1111, 4'b0001, 4'b1100);
        directed("slt_only",   4'b0001, 4'b0111, 4'b0100);
        directed("neg_vs_0",   4'b1111, 4'b0000, 4'b1100);
        directed("pos_vs_neg", 4'b0111, 4'b1000, 4'b0010);
        directed("neg_neg",    4'b1110, 4'b1001, 4'b1010);
        directed("ones_eq",    4'b1111, 4'b1111, 4'b0001);

        // Held inputs: identical result every cycle.
        directed("hold_1",     4'b0101, 4'b0011, 4'b1010);
        directed("hold_2",     4'b0101, 4'b0011, 4'b1010);

        // One-edge reset pulse discards the pending result, then recovers.
        step(4'b0101, 4'b0011, 1'b0);
        check("rst_pulse", o_result, 4'b0000);
        #1;
        step(4'b0101, 4'b0011, 1'b1);
        check("rst_recover", o_result, 4'b1010);
        #1;

        // Exhaustive sweep; the compare process checks every cycle.
        for (int a = 0; a < (1 << BITS); a++) begin
            for (int b = 0; b < (1 << BITS); b++) begin
                step(BITS'(a), BITS'(b), 1'b1);
                #1;
            end
        end

        // Random operands with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            step(BITS'($urandom), BITS'($urandom), ($urandom_range(0, 15) != 0));
            #1;
        end

        step(4'b0000, 4'b0000, 1'b1);
        @(negedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
